// File: rtl/watch_pkg.sv
// Shared encodings and default timing parameters for the watch time-set logic.
// Auto-repeat is enabled by defining TIME_SET_AUTO_REPEAT_EN.
package watch_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } set_mode_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 16;
    localparam int DEF_REPEAT_PERIOD   = 4;
    localparam int DEF_IDLE_TIMEOUT    = 64;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw pushbutton.
// flip pulses for one cycle in the cycle the debounced level changes.
module btn_debounce
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic flip
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            flip  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            flip <= 1'b0;
            if (sync[1] != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt   <= '0;
                    level <= sync[1];
                    flip  <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: mode/up/down buttons drive set_mode, clock_enable and
// single-cycle inc/dec pulses. Define TIME_SET_AUTO_REPEAT_EN for auto-repeat.
module time_set_ctrl
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int IDLE_TIMEOUT    = DEF_IDLE_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       min_inc,
    output logic       min_dec,
    output logic       hour_inc,
    output logic       hour_dec,
    output logic       clock_enable,
    output logic [1:0] set_mode
);

    // Hold and repeat counters share one width.
    localparam int HW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    logic mode_level, mode_flip;
    logic up_level, up_flip;
    logic down_level, down_flip;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .reset_n(reset_n), .raw(btn_mode),
        .level(mode_level), .flip(mode_flip)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .reset_n(reset_n), .raw(btn_up),
        .level(up_level), .flip(up_flip)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .reset_n(reset_n), .raw(btn_down),
        .level(down_level), .flip(down_flip)
    );

    logic mode_rise, mode_fall, up_rise, down_rise;
    assign mode_rise = mode_flip & mode_level;
    assign mode_fall = mode_flip & ~mode_level;
    assign up_rise   = up_flip & up_level;
    assign down_rise = down_flip & down_level;

    set_mode_e     state_q, state_d;
    logic          ce_q, ce_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          armed_q, armed_d;
    logic          long_q, long_d;
    logic          fire_up, fire_dn, active;
    logic          hi_d, hd_d, mi_d, md_d;
`ifdef TIME_SET_AUTO_REPEAT_EN
    logic [HW-1:0] rep_q, rep_d;
    logic          rep_act_q, rep_act_d;
`endif

    always_comb begin
        state_d = state_q;
        ce_d    = ce_q;
        idle_d  = idle_q;
        hold_d  = hold_q;
        armed_d = armed_q;
        long_d  = long_q;
        fire_up = 1'b0;
        fire_dn = 1'b0;
        active  = 1'b0;
`ifdef TIME_SET_AUTO_REPEAT_EN
        rep_d     = '0;
        rep_act_d = 1'b0;
`endif
        unique case (state_q)
            RUN: begin
                idle_d = '0;
                // Only a press that began in RUN may toggle or advance.
                if (mode_rise) begin
                    armed_d = 1'b1;
                    hold_d  = '0;
                    long_d  = 1'b0;
                end else if (mode_fall) begin
                    if (armed_q && !long_q) state_d = SET_HOUR;
                    armed_d = 1'b0;
                    hold_d  = '0;
                    long_d  = 1'b0;
                end else if (armed_q && mode_level && !long_q) begin
                    if (hold_q == HW'(REPEAT_DELAY - 1)) begin
                        ce_d   = ~ce_q;
                        long_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            SET_HOUR, SET_MIN: begin
                armed_d = 1'b0;
                hold_d  = '0;
                long_d  = 1'b0;
                if (mode_rise) begin
                    if (state_q == SET_HOUR) state_d = SET_MIN;
                    else                     state_d = RUN;
                    idle_d = '0;
                end else begin
                    fire_up = up_rise & ~down_level;
                    fire_dn = down_rise & ~up_level;
                    active  = up_rise | down_rise;
`ifdef TIME_SET_AUTO_REPEAT_EN
                    if (fire_up || fire_dn) begin
                        rep_act_d = 1'b1;
                    end else if (rep_act_q && (up_level ^ down_level)) begin
                        rep_act_d = 1'b1;
                        if (rep_q == HW'(REPEAT_DELAY - 1)) begin
                            rep_d   = HW'(REPEAT_DELAY - REPEAT_PERIOD);
                            fire_up = up_level;
                            fire_dn = down_level;
                            active  = 1'b1;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end
`endif
                    if (active) begin
                        idle_d = '0;
                    end else if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
                        state_d = RUN;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
        hi_d = fire_up && (state_q == SET_HOUR);
        hd_d = fire_dn && (state_q == SET_HOUR);
        mi_d = fire_up && (state_q == SET_MIN);
        md_d = fire_dn && (state_q == SET_MIN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            ce_q     <= 1'b1;
            idle_q   <= '0;
            hold_q   <= '0;
            armed_q  <= 1'b0;
            long_q   <= 1'b0;
            hour_inc <= 1'b0;
            hour_dec <= 1'b0;
            min_inc  <= 1'b0;
            min_dec  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ce_q     <= ce_d;
            idle_q   <= idle_d;
            hold_q   <= hold_d;
            armed_q  <= armed_d;
            long_q   <= long_d;
            hour_inc <= hi_d;
            hour_dec <= hd_d;
            min_inc  <= mi_d;
            min_dec  <= md_d;
        end
    end

`ifdef TIME_SET_AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_q     <= '0;
            rep_act_q <= 1'b0;
        end else begin
            rep_q     <= rep_d;
            rep_act_q <= rep_act_d;
        end
    end
`endif

    assign set_mode     = state_q;
    assign clock_enable = ce_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: button-press table plus timing sequences.
// Expectations follow TIME_SET_AUTO_REPEAT_EN when it is defined.
module tb_time_set_ctrl;

    logic       clk;
    logic       reset_n;
    logic       btn_mode, btn_up, btn_down;
    logic       min_inc, min_dec, hour_inc, hour_dec;
    logic       clock_enable;
    logic [1:0] set_mode;

    int errors = 0;
    int checks = 0;
    int onehot_bad = 0;

    time_set_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .min_inc(min_inc), .min_dec(min_dec),
        .hour_inc(hour_inc), .hour_dec(hour_dec),
        .clock_enable(clock_enable), .set_mode(set_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (reset_n && !$onehot0({min_inc, min_dec, hour_inc, hour_dec}))
            onehot_bad++;

    typedef struct {
        string name;
        logic  m, u, d;
        int    len, gap;
        int    e_mode;
        int    e_ce;
        int    e_hi, e_hd, e_mi, e_md;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Press the given buttons for len cycles, then idle gap cycles,
    // counting every pulse seen in the window.
    task automatic apply(input vec_t v);
        int hi = 0, hd = 0, mi = 0, md = 0;
        btn_mode = v.m;
        btn_up   = v.u;
        btn_down = v.d;
        for (int i = 1; i <= v.len + v.gap; i++) begin
            @(negedge clk);
            hi += int'(hour_inc);
            hd += int'(hour_dec);
            mi += int'(min_inc);
            md += int'(min_dec);
            if (i == v.len) begin
                btn_mode = 1'b0;
                btn_up   = 1'b0;
                btn_down = 1'b0;
            end
        end
        chk({v.name, " set_mode"}, int'(set_mode), v.e_mode);
        chk({v.name, " clock_enable"}, int'(clock_enable), v.e_ce);
        chk({v.name, " hour_inc"}, hi, v.e_hi);
        chk({v.name, " hour_dec"}, hd, v.e_hd);
        chk({v.name, " min_inc"}, mi, v.e_mi);
        chk({v.name, " min_dec"}, md, v.e_md);
    endtask

    initial begin
        int cnt, first, second, other;
        int exp_cnt, exp_second;

        vecs[0]  = '{"mode_short_run", 1, 0, 0, 8, 12, 1, 1, 0, 0, 0, 0};
        vecs[1]  = '{"up_glitch", 0, 1, 0, 2, 12, 1, 1, 0, 0, 0, 0};
        vecs[2]  = '{"hour_up", 0, 1, 0, 8, 12, 1, 1, 1, 0, 0, 0};
        vecs[3]  = '{"hour_down", 0, 0, 1, 8, 12, 1, 1, 0, 1, 0, 0};
        vecs[4]  = '{"mode_to_min", 1, 0, 0, 8, 12, 2, 1, 0, 0, 0, 0};
        vecs[5]  = '{"min_up", 0, 1, 0, 8, 12, 2, 1, 0, 0, 1, 0};
        vecs[6]  = '{"min_down", 0, 0, 1, 8, 12, 2, 1, 0, 0, 0, 1};
        vecs[7]  = '{"min_both", 0, 1, 1, 40, 12, 2, 1, 0, 0, 0, 0};
        vecs[8]  = '{"mode_to_run", 1, 0, 0, 8, 12, 0, 1, 0, 0, 0, 0};
        vecs[9]  = '{"run_up", 0, 1, 0, 8, 12, 0, 1, 0, 0, 0, 0};
        vecs[10] = '{"long_mode_off", 1, 0, 0, 20, 12, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{"long_mode_on", 1, 0, 0, 20, 12, 0, 1, 0, 0, 0, 0};

`ifdef TIME_SET_AUTO_REPEAT_EN
        exp_cnt    = 7;
        exp_second = 23;
`else
        exp_cnt    = 1;
        exp_second = -1;
`endif

        reset_n  = 1'b0;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset set_mode", int'(set_mode), 0);
        chk("reset clock_enable", int'(clock_enable), 1);
        chk("reset pulses", int'({min_inc, min_dec, hour_inc, hour_dec}), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[k]) apply(vecs[k]);

        // Short mode press in RUN: set_mode follows the debounced release.
        btn_mode = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 8) btn_mode = 1'b0;
            if (i == 14) chk("mode release -1", int'(set_mode), 0);
            if (i == 15) chk("mode release +0", int'(set_mode), 1);
        end

        // Up press: hour_inc for exactly the cycle 7 after the raw rise.
        btn_up = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 6) chk("hour_inc at 6", int'(hour_inc), 0);
            if (i == 7) chk("hour_inc at 7", int'(hour_inc), 1);
            if (i == 8) begin
                chk("hour_inc at 8", int'(hour_inc), 0);
                btn_up = 1'b0;
            end
        end

        // Down held 40 cycles in SET_HOUR.
        cnt = 0; first = -1; second = -1; other = 0;
        btn_down = 1'b1;
        for (int i = 1; i <= 55; i++) begin
            @(negedge clk);
            if (i == 40) btn_down = 1'b0;
            if (hour_dec) begin
                cnt++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            other += int'(hour_inc) + int'(min_inc) + int'(min_dec);
        end
        chk("hold hour_dec count", cnt, exp_cnt);
        chk("hold first pulse", first, 7);
        chk("hold second pulse", second, exp_second);
        chk("hold other pulses", other, 0);

        // Mode into SET_MIN, then idle until the timeout forces RUN.
        btn_mode = 1'b1;
        for (int i = 1; i <= 75; i++) begin
            @(negedge clk);
            if (i == 8) btn_mode = 1'b0;
            if (i == 10) chk("idle entered SET_MIN", int'(set_mode), 2);
            if (i == 70) chk("idle before timeout", int'(set_mode), 2);
            if (i == 71) chk("idle after timeout", int'(set_mode), 0);
        end

        // Long press turns clock_enable off, short press enters SET_HOUR.
        btn_mode = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 20) btn_mode = 1'b0;
        end
        chk("pre-reset long ce", int'(clock_enable), 0);
        chk("pre-reset long mode", int'(set_mode), 0);
        btn_mode = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 8) btn_mode = 1'b0;
        end
        chk("pre-reset set_mode", int'(set_mode), 1);

        // Reset while a down pulse is high and the button is still held.
        btn_down = 1'b1;
        repeat (7) @(negedge clk);
        chk("pre-reset hour_dec", int'(hour_dec), 1);
        reset_n = 1'b0;
        #1;
        chk("async reset hour_dec", int'(hour_dec), 0);
        chk("async reset set_mode", int'(set_mode), 0);
        chk("async reset ce", int'(clock_enable), 1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            cnt += int'(hour_inc) + int'(hour_dec);
            cnt += int'(min_inc) + int'(min_dec);
        end
        chk("post-reset hold pulses", cnt, 0);
        chk("post-reset set_mode", int'(set_mode), 0);
        btn_down = 1'b0;
        repeat (12) @(negedge clk);

        chk("one-hot pulse cycles", onehot_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
